// File: rtl/keypad_scanner.sv
// Module: keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time, classifies each
// full scan frame as NONE / ONE(key) / MULTI and debounces presses and
// releases over DEBOUNCE_FRAMES identical frames. Emits a registered hex code,
// a one-cycle key_valid strobe per accepted press and a key_held level.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 12000,
    parameter int unsigned DEBOUNCE_FRAMES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Keymap lookup: row r, column c -> hex digit.
    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // Scan and synchronizer state
    logic [DIV_W-1:0] div_q;
    logic [1:0]       col_idx_q;
    logic [3:0]       row_s1;
    logic [3:0]       row_s2;
    logic [1:0]       acc_cnt_q;
    logic [3:0]       acc_code_q;

    // Debounce FSM state
    state_t           state_q, state_n;
    logic [3:0]       cand_q, cand_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [3:0]       key_n;
    logic             held_n;
    logic             valid_n;

    // Frame classification
    logic       dwell_end_c;
    logic       frame_end_c;
    logic [3:0] row_low_c;
    logic [2:0] nlow_c;
    logic [1:0] row_idx_c;
    logic [3:0] hit_code_c;
    logic [2:0] sum_c;
    logic [1:0] frame_cnt_c;
    logic [3:0] frame_code_c;
    logic       one_c;
    logic       none_c;

    assign dwell_end_c = (div_q == DIV_LAST);
    assign frame_end_c = dwell_end_c && (col_idx_q == 2'd3);
    assign row_low_c   = ~row_s2;
    assign nlow_c      = 3'($countones(row_low_c));

    // Row index of the (single) low row in the current column.
    always_comb begin
        row_idx_c = 2'd0;
        if (row_low_c[0])      row_idx_c = 2'd0;
        else if (row_low_c[1]) row_idx_c = 2'd1;
        else if (row_low_c[2]) row_idx_c = 2'd2;
        else if (row_low_c[3]) row_idx_c = 2'd3;
    end

    assign hit_code_c   = keymap(row_idx_c, col_idx_q);
    assign sum_c        = 3'(acc_cnt_q) + nlow_c;
    assign frame_cnt_c  = (sum_c >= 3'd2) ? 2'd2 : sum_c[1:0];
    assign frame_code_c = (acc_cnt_q == 2'd0) ? hit_code_c : acc_code_q;
    assign one_c        = frame_end_c && (frame_cnt_c == 2'd1);
    assign none_c       = frame_end_c && (frame_cnt_c == 2'd0);

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
        end
    end

    // Column dwell counter, column rotation and per-frame hit accumulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q      <= '0;
            col_idx_q  <= 2'd0;
            col        <= 4'b1110;
            acc_cnt_q  <= 2'd0;
            acc_code_q <= 4'h0;
        end else if (dwell_end_c) begin
            div_q     <= '0;
            col_idx_q <= col_idx_q + 2'd1;
            col       <= {col[2:0], col[3]};
            if (frame_end_c) begin
                acc_cnt_q  <= 2'd0;
                acc_code_q <= 4'h0;
            end else begin
                acc_cnt_q  <= frame_cnt_c;
                acc_code_q <= frame_code_c;
            end
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Debounce FSM state and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cand_q    <= 4'h0;
            cnt_q     <= '0;
            key       <= 4'h0;
            key_held  <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            state_q   <= state_n;
            cand_q    <= cand_n;
            cnt_q     <= cnt_n;
            key       <= key_n;
            key_held  <= held_n;
            key_valid <= valid_n;
        end
    end

    // Debounce FSM next-state: steps only on the frame-end cycle.
    always_comb begin
        state_n = state_q;
        cand_n  = cand_q;
        cnt_n   = cnt_q;
        key_n   = key;
        held_n  = key_held;
        valid_n = 1'b0;
        if (frame_end_c) begin
            case (state_q)
                IDLE: begin
                    if (one_c) begin
                        cand_n = frame_code_c;
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_n = PRESSED;
                            key_n   = frame_code_c;
                            held_n  = 1'b1;
                            valid_n = 1'b1;
                            cnt_n   = CNT_ZERO;
                        end else begin
                            state_n = DEBOUNCE;
                            cnt_n   = CNT_ONE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (one_c) begin
                        if (frame_code_c == cand_q) begin
                            if (cnt_q == CNT_LAST) begin
                                state_n = PRESSED;
                                key_n   = cand_q;
                                held_n  = 1'b1;
                                valid_n = 1'b1;
                                cnt_n   = CNT_ZERO;
                            end else begin
                                cnt_n = cnt_q + CNT_ONE;
                            end
                        end else begin
                            cand_n = frame_code_c;
                            cnt_n  = CNT_ONE;
                        end
                    end else begin
                        state_n = IDLE;
                        cnt_n   = CNT_ZERO;
                    end
                end
                PRESSED: begin
                    if (none_c) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_n = IDLE;
                            held_n  = 1'b0;
                            cnt_n   = CNT_ZERO;
                        end else begin
                            state_n = RELEASE;
                            cnt_n   = CNT_ONE;
                        end
                    end
                end
                RELEASE: begin
                    if (none_c) begin
                        if (cnt_q == CNT_LAST) begin
                            state_n = IDLE;
                            held_n  = 1'b0;
                            cnt_n   = CNT_ZERO;
                        end else begin
                            cnt_n = cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_n = PRESSED;
                        cnt_n   = CNT_ZERO;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: keypad matrix model, frame-level reference
// model, directed vector table, reset corner case and random key sequences.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DF = 3;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    // Set of pressed keys, bit index = row*4 + col.
    logic [15:0] pk = 16'h0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

    // Reference model state (frame granularity).
    int         m_state;   // 0 idle, 1 debouncing, 2 pressed, 3 releasing
    logic [3:0] m_cand;
    int         m_cnt;
    logic [3:0] m_key;
    logic       m_held;
    logic       m_pulse;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a row is pulled low when a pressed key sits on a low column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pk[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = 0; m_cand = 4'h0; m_cnt = 0;
        m_key = 4'h0; m_held = 1'b0; m_pulse = 1'b0;
    endfunction

    // Apply one full frame's result to the debounce rules.
    function automatic void model_frame(input logic [15:0] set);
        int nk;
        logic [3:0] code;
        nk = $countones(set);
        code = 4'h0;
        for (int i = 15; i >= 0; i--) if (set[i]) code = kmap[i];
        m_pulse = 1'b0;
        case (m_state)
            0: if (nk == 1) begin
                m_cand = code; m_cnt = 1; m_state = 1;
            end
            1: if (nk == 1 && code == m_cand) begin
                m_cnt++;
            end else if (nk == 1) begin
                m_cand = code; m_cnt = 1;
            end else begin
                m_state = 0;
            end
            2: if (nk == 0) begin
                m_state = 3; m_cnt = 1;
            end
            default: if (nk == 0) m_cnt++; else m_state = 2;
        endcase
        if (m_state == 1 && m_cnt >= DF) begin
            m_state = 2; m_key = m_cand; m_held = 1'b1; m_pulse = 1'b1;
        end
        if (m_state == 3 && m_cnt >= DF) begin
            m_state = 0; m_held = 1'b0;
        end
    endfunction

    // Run one frame with a fixed key set; called at a negedge at frame start.
    task automatic run_frame(input logic [15:0] set, inout int pulses);
        logic [3:0] exp_col;
        pk = set;
        for (int i = 0; i < FRAME; i++) begin
            @(posedge clk);
            #1;
            if (i == FRAME - 1) model_frame(set);
            else m_pulse = 1'b0;
            exp_col = 4'hF;
            exp_col[((i + 1) % FRAME) / SD] = 1'b0;
            check("col", 32'(col), 32'(exp_col));
            check("key_valid", 32'(key_valid), 32'(m_pulse));
            check("key", 32'(key), 32'(m_key));
            check("key_held", 32'(key_held), 32'(m_held));
            if (key_valid) pulses++;
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] set;
        int          frames;
        int          pulses;
        logic [3:0]  key;
        logic        held;
    } vec_t;

    localparam int NV = 21;
    vec_t vt [NV];

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int p;
        logic [15:0] s;
        int nf;
        int sel;

        vt[0]  = '{16'h0040, 5, 1, 4'h6, 1'b1};
        vt[1]  = '{16'h0000, 2, 0, 4'h6, 1'b1};
        vt[2]  = '{16'h0000, 1, 0, 4'h6, 1'b0};
        vt[3]  = '{16'h0002, 2, 0, 4'h6, 1'b0};
        vt[4]  = '{16'h0000, 1, 0, 4'h6, 1'b0};
        vt[5]  = '{16'h0002, 2, 0, 4'h6, 1'b0};
        vt[6]  = '{16'h0002, 1, 1, 4'h2, 1'b1};
        vt[7]  = '{16'h0000, 3, 0, 4'h2, 1'b0};
        vt[8]  = '{16'h0420, 4, 0, 4'h2, 1'b0};
        vt[9]  = '{16'h0000, 1, 0, 4'h2, 1'b0};
        vt[10] = '{16'h0001, 3, 1, 4'h1, 1'b1};
        vt[11] = '{16'h0003, 3, 0, 4'h1, 1'b1};
        vt[12] = '{16'h0000, 3, 0, 4'h1, 1'b0};
        vt[13] = '{16'h1000, 3, 1, 4'hE, 1'b1};
        vt[14] = '{16'h0000, 3, 0, 4'hE, 1'b0};
        vt[15] = '{16'h4000, 3, 1, 4'hF, 1'b1};
        vt[16] = '{16'h0000, 3, 0, 4'hF, 1'b0};
        vt[17] = '{16'h2000, 3, 1, 4'h0, 1'b1};
        vt[18] = '{16'h0000, 3, 0, 4'h0, 1'b0};
        vt[19] = '{16'h8000, 3, 1, 4'hD, 1'b1};
        vt[20] = '{16'h0000, 3, 0, 4'hD, 1'b0};

        // Reset state
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_col", 32'(col), 32'h0000000E);
        check("rst_key", 32'(key), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_held", 32'(key_held), 32'h0);
        reset = 1'b0;

        // Directed vector table
        for (int v = 0; v < NV; v++) begin
            p = 0;
            for (int f = 0; f < vt[v].frames; f++) run_frame(vt[v].set, p);
            check($sformatf("vec%0d_pulses", v), 32'(p), 32'(vt[v].pulses));
            check($sformatf("vec%0d_key", v), 32'(key), 32'(vt[v].key));
            check($sformatf("vec%0d_held", v), 32'(key_held), 32'(vt[v].held));
        end

        // Reset while key 8 is held, then re-debounce
        p = 0;
        for (int f = 0; f < 4; f++) run_frame(16'h0200, p);
        check("pre_rst_pulses", 32'(p), 32'd1);
        check("pre_rst_key", 32'(key), 32'h8);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_col", 32'(col), 32'h0000000E);
        check("async_key", 32'(key), 32'h0);
        check("async_valid", 32'(key_valid), 32'h0);
        check("async_held", 32'(key_held), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        p = 0;
        for (int f = 0; f < 3; f++) run_frame(16'h0200, p);
        check("post_rst_pulses", 32'(p), 32'd1);
        check("post_rst_key", 32'(key), 32'h8);
        check("post_rst_held", 32'(key_held), 32'h1);
        p = 0;
        for (int f = 0; f < 3; f++) run_frame(16'h0000, p);
        check("post_rst_release", 32'(key_held), 32'h0);

        // Random key sequences against the reference model
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 25) s = 16'h0;
            else if (sel < 85) begin
                s = 16'h0;
                s[$urandom_range(0, 15)] = 1'b1;
            end else begin
                s = 16'h0;
                s[$urandom_range(0, 15)] = 1'b1;
                s[$urandom_range(0, 15)] = 1'b1;
            end
            nf = int'($urandom_range(1, 5));
            p = 0;
            for (int f = 0; f < nf; f++) run_frame(s, p);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
